// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT constants, mode encoding and modular add/sub/half helpers.
package ntt_pkg;
  localparam int NTT_W = 23;
  localparam int unsigned NTT_Q = 8380417;
  localparam logic MODE_CT = 1'b0;
  localparam logic MODE_GS = 1'b1;
  function automatic logic [NTT_W-1:0] mod_add(input logic [NTT_W-1:0] a, b, q);
    logic [NTT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= {1'b0, q} ? NTT_W'(s - {1'b0, q}) : NTT_W'(s);
  endfunction
  // Wrapping W-bit arithmetic lands on the right value because the true result is < q.
  function automatic logic [NTT_W-1:0] mod_sub(input logic [NTT_W-1:0] a, b, q);
    return a < b ? a - b + q : a - b;
  endfunction
  function automatic logic [NTT_W-1:0] mod_half(input logic [NTT_W-1:0] v, q);
    logic [NTT_W:0] s;
    s = {1'b0, v} + (v[0] ? {1'b0, q} : '0);
    return s[NTT_W:1];
  endfunction
endpackage

// File: rtl/mul_mod_pipe.sv
// mul_mod_pipe: pipelined modular multiplier, p = a*b mod Q after exactly MUL_LAT enabled cycles.
module mul_mod_pipe import ntt_pkg::*; #(
  parameter int W = NTT_W,
  parameter int unsigned Q = NTT_Q,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);
  localparam logic [W-1:0] QW = W'(Q);
  // Shift-subtract reduction; the running remainder stays below Q so W+1 bits suffice.
  function automatic logic [W-1:0] reduce(input logic [2*W-1:0] v);
    logic [W:0] r;
    r = '0;
    for (int i = 2*W-1; i >= 0; i--) begin
      r = {r[W-1:0], v[i]};
      if (r >= {1'b0, QW}) r = r - {1'b0, QW};
    end
    return r[W-1:0];
  endfunction
  if (MUL_LAT == 1) begin : g_one
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) p <= '0;
      else if (en) p <= reduce({{W{1'b0}}, a} * {{W{1'b0}}, b});
  end else begin : g_multi
    logic [2*W-1:0] prod;
    logic [W-1:0] r [MUL_LAT-1];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        prod <= '0;
        for (int i = 0; i < MUL_LAT-1; i++) r[i] <= '0;
      end else if (en) begin
        prod <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r[0] <= reduce(prod);
        for (int i = 1; i < MUL_LAT-1; i++) r[i] <= r[i-1];
      end
    assign p = r[MUL_LAT-2];
  end
endmodule

// File: rtl/bu_pipe.sv
// bu_pipe: pipelined CT/GS NTT butterfly, LAT = MUL_LAT+2, valid/ready with a global advance enable.
// Optional BU_PIPE_INTT_HALF_EN: GS results are halved mod Q in the final stage.
module bu_pipe import ntt_pkg::*; #(
  parameter int W = NTT_W,
  parameter int unsigned Q = NTT_Q,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic [W-1:0] in_tf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         busy
);
  localparam logic [W-1:0] QW = W'(Q);
  logic adv;
  logic [MUL_LAT:0] vs, ms;
  logic [W-1:0] xs [MUL_LAT+1];
  logic [W-1:0] ma, tf, p, fa, fb, ga, gb;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  assign busy = |vs || out_valid;
  // Index 0 is S0; index MUL_LAT lines up with the multiplier output.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vs <= '0;
      out_valid <= 1'b0;
      out_a <= '0;
      out_b <= '0;
    end else if (adv) begin
      vs <= {vs[MUL_LAT-1:0], in_valid};
      out_valid <= vs[MUL_LAT];
      out_a <= ms[MUL_LAT] == MODE_GS ? ga : fa;
      out_b <= ms[MUL_LAT] == MODE_GS ? gb : fb;
    end
  always_ff @(posedge clk)
    if (adv) begin
      ms <= {ms[MUL_LAT-1:0], in_mode};
      xs[0] <= in_mode == MODE_GS ? mod_add(in_x, in_y, QW) : in_x;
      for (int i = 1; i <= MUL_LAT; i++) xs[i] <= xs[i-1];
      ma <= in_mode == MODE_GS ? mod_sub(in_x, in_y, QW) : in_y;
      tf <= in_tf;
    end
  mul_mod_pipe #(.W(W), .Q(Q), .MUL_LAT(MUL_LAT)) u_mul (
    .clk(clk), .rst_n(rst_n), .en(adv), .a(ma), .b(tf), .p(p)
  );
  assign fa = mod_add(xs[MUL_LAT], p, QW);
  assign fb = mod_sub(xs[MUL_LAT], p, QW);
`ifdef BU_PIPE_INTT_HALF_EN
  assign ga = mod_half(xs[MUL_LAT], QW);
  assign gb = mod_half(p, QW);
`else
  assign ga = xs[MUL_LAT];
  assign gb = p;
`endif
endmodule

// File: tb/tb_bu_pipe.sv
// tb_bu_pipe: randomized and directed checks of bu_pipe against an arithmetic reference model.
module tb_bu_pipe;
  localparam longint QL = 8380417;
  localparam longint INV2 = (QL + 1) / 2;
  localparam int LAT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [22:0] in_x = '0, in_y = '0, in_tf = '0;
  logic in_ready, out_valid, busy;
  logic [22:0] out_a, out_b;
  typedef struct {longint a, b; int cyc, st;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0, cyc = 0, stalls = 0, n_out = 0, base;
  longint ea, eb, last_a = -1, last_b = -1;
  bit due, done;

  bu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_tf(in_tf), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model(input bit m, input longint x, y, tf, output longint a, b);
    if (!m) begin
      a = (x + y * tf % QL) % QL;
      b = (x - y * tf % QL + QL) % QL;
    end else begin
      a = (x + y) % QL;
      b = (x - y + QL) % QL * tf % QL;
`ifdef BU_PIPE_INTT_HALF_EN
      a = a * INV2 % QL;
      b = b * INV2 % QL;
`endif
    end
  endfunction

  // Each stall cycle freezes the whole pipe, so it shifts every in-flight beat's due cycle by one.
  always @(negedge clk)
    if (rst_n) begin
      due = q.size() > 0 && cyc >= q[0].cyc + LAT + (stalls - q[0].st);
      check("busy", busy, q.size() > 0);
      check("out_valid", out_valid, due);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        check("out_a", out_a, e.a);
        check("out_b", out_b, e.b);
        last_a = out_a;
        last_b = out_b;
        n_out++;
      end
      if (in_valid && in_ready) begin
        model(in_mode, in_x, in_y, in_tf, ea, eb);
        q.push_back('{ea, eb, cyc, stalls});
      end
      if (!in_ready) stalls++;
    end

  task automatic put(input bit v, input bit m, input longint x, y, tf);
    int k = 0;
    in_valid = v;
    in_mode = m;
    in_x = 23'(x);
    in_y = 23'(y);
    in_tf = 23'(tf);
    do begin
      @(negedge clk);
      k++;
    end while (v && !in_ready && k < 100);
    if (v && !in_ready) check("put_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain", busy, 0);
    @(posedge clk);
    #1;
  endtask

  function automatic longint rv();
    int s = $urandom_range(0, 9);
    return s == 0 ? 0 : s == 1 ? QL - 1 : longint'($urandom_range(0, 8380416));
  endfunction

  initial begin
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    put(1, 0, 5, 3, 2);
    drain();
    check("ct_basic_a", last_a, 11);
    check("ct_basic_b", last_b, 8380416);
    put(1, 1, 5, 3, 2);
    drain();
`ifdef BU_PIPE_INTT_HALF_EN
    check("gs_basic_a", last_a, 4);
    check("gs_basic_b", last_b, 2);
    put(1, 1, 1, 0, 1);
    drain();
    check("gs_odd_a", last_a, 4190209);
    check("gs_odd_b", last_b, 4190209);
`else
    check("gs_basic_a", last_a, 8);
    check("gs_basic_b", last_b, 4);
`endif
    put(1, 0, 8380416, 1, 1);
    drain();
    check("wrap1_a", last_a, 0);
    check("wrap1_b", last_b, 8380415);
    put(1, 0, 0, 8380416, 8380416);
    drain();
    check("wrap2_a", last_a, 1);
    check("wrap2_b", last_b, 8380416);
    base = n_out;
    fork
      for (int i = 0; i < 8; i++) put(1, i[0], rv(), rv(), rv());
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", n_out - base, 8);
    base = n_out;
    put(1, 0, rv(), rv(), rv());
    put(0, 0, 0, 0, 0);
    put(1, 1, rv(), rv(), rv());
    put(1, 0, rv(), rv(), rv());
    put(0, 0, 0, 0, 0);
    drain();
    check("bubble_count", n_out - base, 3);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++)
          put($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rv(), rv(), rv());
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1 out_ready = $urandom_range(0, 3) != 0;
      end
    join
    out_ready = 1'b1;
    drain();
    for (int i = 0; i < 3; i++) put(1, i[0], rv(), rv(), rv());
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_a", out_a, 0);
    check("mid_rst_out_b", out_b, 0);
    check("mid_rst_in_ready", in_ready, 1);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    base = n_out;
    put(1, 0, 5, 3, 2);
    drain();
    check("after_rst_count", n_out - base, 1);
    check("after_rst_a", last_a, 11);
    check("after_rst_b", last_b, 8380416);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
